// File: rtl/fir_lp.sv
//==============================================================================
// Module   : fir_lp
// Purpose  : Time-multiplexed low-pass FIR filter for the equalizer low band.
//            One multiplier-accumulator walks all taps of a circular delay
//            line per accepted sample; coefficients are runtime-loadable.
// Ports    : clk, rst (async, active-high)
//            sample_in/sample_valid  - signed 16-bit PCM input + strobe
//            busy                    - high while a sample is processed
//            filtered_out/out_valid  - signed 16-bit result + 1-cycle pulse
//            coef_we/addr/data       - signed Q1.15 coefficient write port
// Config   : FIR_LP_ROUND_EN - round-half-up before the >>>15 scaling
//            (undefined: truncate toward negative infinity).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fir_lp #(
  parameter int TAPS   = 16,
  parameter int COEF_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              sample_in,
  input  logic                     sample_valid,
  output logic                     busy,
  output logic [15:0]              filtered_out,
  output logic                     out_valid,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data
);

  localparam int AW    = $clog2(TAPS);
  localparam int PW    = 16 + COEF_W;   // product width
  localparam int ACC_W = PW + AW;       // wide enough that TAPS products cannot overflow
  localparam int SW    = ACC_W + 1;     // headroom for the rounding constant

  localparam logic [AW-1:0]     C_LAST   = AW'(TAPS - 1);
  localparam logic [AW-1:0]     C_TAPS_M = AW'(TAPS);   // TAPS modulo 2^AW
  localparam logic [COEF_W-1:0] C_C0_RST = {1'b0, {(COEF_W-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [15:0]         dl_q   [TAPS];
  logic [COEF_W-1:0]   coef_q [TAPS];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       base_q;     // slot holding the newest sample x[n]
  logic [AW-1:0]       k_q;        // current tap index
  logic signed [ACC_W-1:0] acc_q;
  logic [15:0]         filt_q;
  logic                ovalid_q;

  logic                    w_accept;
  logic                    w_coef_wr;
  logic                    w_addr_ok;
  logic                    w_last;
  logic [AW-1:0]           w_idx;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_acc_sum;
  logic signed [SW-1:0]    w_rnd;
  logic signed [SW-1:0]    w_shr;
  logic                    w_fits;
  logic [15:0]             w_sat;

  // With a power-of-two tap count every address is in range.
  if (TAPS == (1 << AW)) begin : g_addr_full
    assign w_addr_ok = 1'b1;
  end else begin : g_addr_chk
    assign w_addr_ok = ({1'b0, coef_addr} < (AW+1)'(TAPS));
  end

  assign w_accept  = (state_q == S_IDLE) && sample_valid;
  assign w_coef_wr = (state_q == S_IDLE) && coef_we && w_addr_ok;
  assign w_last    = (state_q == S_MAC) && (k_q == C_LAST);

  // x[n-k] lives at (base - k) mod TAPS. The true index is below TAPS, so
  // computing base + TAPS - k modulo 2^AW is exact.
  assign w_idx = (base_q >= k_q) ? (base_q - k_q) : (base_q + C_TAPS_M - k_q);

  assign w_prod    = $signed(dl_q[w_idx]) * $signed(coef_q[k_q]);
  assign w_acc_sum = acc_q + $signed({{AW{w_prod[PW-1]}}, w_prod});

`ifdef FIR_LP_ROUND_EN
  assign w_rnd = $signed({w_acc_sum[ACC_W-1], w_acc_sum}) + $signed(SW'(1 << 14));
`else
  assign w_rnd = $signed({w_acc_sum[ACC_W-1], w_acc_sum});
`endif

  assign w_shr  = w_rnd >>> 15;
  // Result fits in 16 bits when everything above bit 14 is pure sign.
  assign w_fits = (&w_shr[SW-1:15]) | ~(|w_shr[SW-1:15]);
  assign w_sat  = w_fits ? w_shr[15:0] : (w_shr[SW-1] ? 16'h8000 : 16'h7FFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sample_valid) state_d = S_MAC;
      S_MAC:   if (k_q == C_LAST) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The final product is folded in and the scaled result registered on the
  // last MAC edge, so the result and its strobe are presented during OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        dl_q[i]   <= '0;
        coef_q[i] <= (i == 0) ? C_C0_RST : '0;
      end
      wr_ptr_q <= '0;
      base_q   <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      filt_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      ovalid_q <= w_last;
      if (w_last) filt_q <= w_sat;

      if (w_accept) begin
        dl_q[wr_ptr_q] <= sample_in;
        base_q         <= wr_ptr_q;
        wr_ptr_q       <= (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + 1'b1;
        acc_q          <= '0;
        k_q            <= '0;
      end else if (state_q == S_MAC) begin
        acc_q <= w_acc_sum;
        k_q   <= w_last ? '0 : k_q + 1'b1;
      end

      if (w_coef_wr) coef_q[coef_addr] <= coef_data;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign filtered_out = filt_q;
  assign out_valid    = ovalid_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_lp.sv
//==============================================================================
// Module   : tb_fir_lp
// Purpose  : Directed self-checking bench for fir_lp (TAPS=16, COEF_W=16).
//            Honours FIR_LP_ROUND_EN when computing passthrough expectations.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fir_lp;

  localparam int TAPS = 16;

`ifdef FIR_LP_ROUND_EN
  localparam logic [15:0] PASS_1234 = 16'h1234;
`else
  localparam logic [15:0] PASS_1234 = 16'h1233;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        busy;
  logic [15:0] filtered_out;
  logic        out_valid;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;

  int errors = 0;
  int checks = 0;

  fir_lp #(.TAPS(TAPS), .COEF_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .busy         (busy),
    .filtered_out (filtered_out),
    .out_valid    (out_valid),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    coef_we      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // Returns at the negedge inside cycle 1 (edge 0 = acceptance edge).
  task automatic start_sample(input logic [15:0] x);
    @(negedge clk);
    sample_in    = x;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Called inside cycle 1; returns inside the cycle holding out_valid.
  task automatic wait_out(output logic [15:0] y, output int lat, output int nbusy);
    y     = 16'hxxxx;
    lat   = -1;
    nbusy = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) nbusy++;
      if (out_valid) begin
        y   = filtered_out;
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_sample(input logic [15:0] x, output logic [15:0] y, output int lat);
    int nb;
    start_sample(x);
    wait_out(y, lat, nb);
  endtask

  initial begin
    logic [15:0] y;
    int          lat;
    int          nb;
    int          cnt;
    int          acc_n, last_acc, ov_n, last_ov, first_ov;

    sample_in = '0; sample_valid = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check_val("rst_filtered_out", filtered_out, 16'h0000);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_busy", busy, 1'b0);

    // Reset coefficients: near-passthrough, latency and busy window
    start_sample(16'h1234);
    wait_out(y, lat, nb);
    check_val("pass_value", y, PASS_1234);
    check_val("pass_latency", lat, TAPS + 1);
    check_val("pass_busy_cycles", nb, TAPS + 1);
    @(negedge clk);
    check_val("pass_out_valid_pulse", out_valid, 1'b0);
    check_val("pass_busy_release", busy, 1'b0);
    check_val("pass_held", filtered_out, PASS_1234);

    // Impulse response with c[k] = k*0x100
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(4'(k), 16'(k * 256));
    do_sample(16'h4000, y, lat);
    check_val("imp_0", y, 16'h0000);
    for (int n = 1; n < TAPS; n++) begin
      do_sample(16'h0000, y, lat);
      check_val($sformatf("imp_%0d", n), y, 16'(n * 128));
    end

    // Saturation, positive then negative
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(4'(k), 16'h7FFF);
    for (int n = 0; n < TAPS; n++) do_sample(16'h7FFF, y, lat);
    check_val("sat_pos", y, 16'h7FFF);
    for (int n = 0; n < TAPS; n++) do_sample(16'h8000, y, lat);
    check_val("sat_neg", y, 16'h8000);

    // Coefficient write on the acceptance edge is used for that sample
    do_reset();
    @(negedge clk);
    sample_in = 16'h1234; sample_valid = 1'b1;
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'h4000;
    @(negedge clk);
    sample_valid = 1'b0; coef_we = 1'b0;
    wait_out(y, lat, nb);
    check_val("same_edge_coef", y, 16'h091A);

    // Coefficient write while busy is ignored; idle write takes effect
    do_reset();
    start_sample(16'h1234);
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'h0000;
    @(negedge clk);
    coef_we = 1'b0;
    wait_out(y, lat, nb);
    check_val("busy_write_ignored", y, PASS_1234);
    do_sample(16'h1234, y, lat);
    check_val("busy_write_next", y, PASS_1234);
    write_coef(4'd0, 16'h0000);
    do_sample(16'h1234, y, lat);
    check_val("idle_write_c0_zero", y, 16'h0000);

    // Reset in MAC cycle 5 aborts and restores everything
    do_reset();
    do_sample(16'h1234, y, lat);
    write_coef(4'd0, 16'h0000);
    write_coef(4'd1, 16'h4000);
    start_sample(16'h2000);
    repeat (4) @(negedge clk);
    check_val("midmac_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_val("midmac_busy", busy, 1'b0);
    check_val("midmac_filtered_out", filtered_out, 16'h0000);
    check_val("midmac_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check_val("midmac_no_out_valid", cnt, 0);
    do_sample(16'h1234, y, lat);
    check_val("midmac_after_value", y, PASS_1234);
    check_val("midmac_after_latency", lat, TAPS + 1);
    do_sample(16'h1234, y, lat);
    check_val("midmac_after_c1_reset", y, PASS_1234);

    // Back-to-back: sample_valid held for 100 cycles
    do_reset();
    acc_n = 0; last_acc = -1; ov_n = 0; last_ov = -1; first_ov = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (last_ov >= 0) check_val("b2b_ov_gap", i - last_ov, TAPS + 2);
        else first_ov = i;
        last_ov = i;
        ov_n++;
      end
      sample_valid = 1'b1;
      sample_in    = 16'(i * 3 + 1);
      if (!busy) begin
        if (last_acc >= 0) check_val("b2b_acc_gap", i - last_acc, TAPS + 2);
        last_acc = i;
        acc_n++;
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
    check_val("b2b_accepts", acc_n, 6);
    check_val("b2b_out_valids", ov_n, 5);
    check_val("b2b_first_ov", first_ov, TAPS + 1);
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir_lp.md
# fir_lp

Time-multiplexed low-pass FIR filter for the audio equalizer's low band. It sits directly upstream of the low-band gain stage. It takes one signed 16-bit PCM sample per handshake and produces one filtered signed 16-bit sample, which feeds the gain stage's `signal_in`. A single multiplier-accumulator iterates over all taps per sample, and the coefficients are runtime-loadable.

## Interface
Parameters:
- `TAPS`, 16: number of filter taps, range 2..64.
- `COEF_W`, 16: coefficient width, signed Q1.15.

Ports:
- `clk`, in, 1: single clock for all logic.
- `rst`, in, 1: asynchronous, active-high reset.
- `sample_in`, in, 16: signed PCM input sample.
- `sample_valid`, in, 1: sample present. Accepted only on a rising edge where `busy`=0.
- `busy`, out, 1: high while a sample is being processed; inputs are dropped while high.
- `filtered_out`, out, 16: signed filtered sample. Registered and held until the next result.
- `out_valid`, out, 1: one-cycle pulse marking a new `filtered_out`.
- `coef_we`, in, 1: coefficient write strobe.
- `coef_addr`, in, clog2(TAPS): tap index to write.
- `coef_data`, in, COEF_W: signed Q1.15 coefficient value.

## Operation
- Delay line: circular buffer of TAPS samples with write pointer `wr_ptr`. An accepted sample is written at `wr_ptr`. `wr_ptr` then advances modulo TAPS, wrapping TAPS-1 to 0.
- Filter equation: y[n] = sum over k=0..TAPS-1 of c[k]·x[n-k]. The newest sample x[n] is paired with c[0].
- FSM states:
  - IDLE: on `sample_valid` with `busy`=0, write the sample, clear the accumulator, go to MAC.
  - MAC: exactly TAPS cycles. Cycle k adds c[k]·x[n-k] to the accumulator. After k=TAPS-1, go to OUT.
  - OUT: one cycle. Scale, saturate and register the result into `filtered_out`; assert `out_valid`. Go to IDLE.
- Widths:
  - Product is 32 bits, Q2.30.
  - Accumulator is 32+clog2(TAPS) bits, signed; it cannot overflow.
  - Result = accumulator >>> 15 (arithmetic shift), saturated to [-32768, 32767].
- `busy` is high in MAC and OUT. `sample_valid` while `busy`=1 is ignored: no queueing, delay line untouched.
- Coefficient writes are taken only when `busy`=0 and `coef_addr` < TAPS; otherwise the write is ignored. A write becomes visible on the next edge.
- If a sample accept and a coefficient write occur on the same edge, both take effect. The new coefficient is used for that sample.
- Reset values:
  - Delay line all 0; `wr_ptr`=0; FSM in IDLE; accumulator 0.
  - `filtered_out`=0, `out_valid`=0, `busy`=0.
  - Coefficients: c[0]=16'h7FFF, all others 0 (near-passthrough).
- Reset asserted mid-MAC or mid-OUT aborts the computation. No `out_valid` is produced, and all state returns to its reset values.

## Timing
- Acceptance edge is cycle 0.
- `busy`=1 from cycle 1 through cycle TAPS+1.
- `out_valid`=1 with the new `filtered_out` in cycle TAPS+1.
- `busy`=0 from cycle TAPS+2. The earliest next acceptance is at edge TAPS+2, so throughput is one sample per TAPS+2 cycles (18 at TAPS=16).
- With `sample_valid` held high continuously, samples are accepted every TAPS+2 cycles.
- `filtered_out` changes only in the cycle `out_valid` rises.

## Configuration
- `FIR_LP_ROUND_EN` defined: add 2^14 to the accumulator before the >>>15 shift, then saturate. This gives round-half-up.
- `FIR_LP_ROUND_EN` undefined: plain arithmetic shift, i.e. truncation toward negative infinity, then saturate.
- Latency and throughput are identical in both builds.

## Test plan
- **Reset coefficients:** after reset, accept 16'h1234 -> `filtered_out`=16'h1233 without the macro, 16'h1234 with it; `out_valid` pulses in cycle 17 after acceptance.
- **Impulse response:** load c[k]=k·16'h0100, then feed 16'h4000 followed by 15 zeros. Successive outputs are 16'h0000, 16'h0080, 16'h0100, …, 16'h0780, identical with or without the macro.
- **Saturation:**
  - All coefficients 16'h7FFF, 16 samples of 16'h7FFF -> final output 16'h7FFF.
  - Same coefficients with 16'h8000 -> 16'h8000.
  - No wrap in either case.
- **Back-to-back input:** `sample_valid` held high for 100 cycles -> exactly 6 acceptances, 18 cycles apart. Intervening samples are dropped and `out_valid` pulses every 18 cycles.
- **Reset mid-MAC:** assert `rst` in MAC cycle 5 -> no `out_valid`; all outputs 0 and coefficients back to reset values. The next sample behaves as the first sample after reset.
- **Coefficient write while busy:** write c[0]=0 during MAC -> ignored; the next sample still passes through. A write to c[0]=0 while idle -> the next output is 16'h0000.
